// File: rtl/tok_pkg.sv
// Shared types and defaults for the tokenizer front end.
package tok_pkg;

    localparam logic [7:0] DEF_SEP         = 8'h20;
    localparam logic [7:0] DEF_TERM        = 8'h00;
    localparam int         DEF_TOKEN_WIDTH = 8;
    localparam int         DEF_MAX_TOKENS  = 64;

    // Each memory access is an ISSUE/CHECK pair: ISSUE presents the
    // registered address, CHECK consumes the returned data.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SKIP_ISSUE,
        ST_SKIP_CHECK,
        ST_CMP_ISSUE,
        ST_CMP_CHECK,
        ST_VSKIP_ISSUE,
        ST_VSKIP_CHECK,
        ST_EMIT,
        ST_WEND_ISSUE,
        ST_WEND_CHECK,
        ST_DONE
    } state_t;

endpackage

// File: rtl/token_encoder_word_cmp.sv
// Character classifier for one step of the word-vs-entry comparison.
module word_cmp
    import tok_pkg::*;
#(
    parameter int unsigned              DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0]    SEP        = DEF_SEP,
    parameter logic [DATA_WIDTH-1:0]    TERM       = DEF_TERM
) (
    input  logic [DATA_WIDTH-1:0] c,
    input  logic [DATA_WIDTH-1:0] v,
    input  logic                  at_entry_start,
    output logic                  c_is_sep,
    output logic                  c_is_term,
    output logic                  v_is_term,
    output logic                  match,
    output logic                  advance,
    output logic                  vocab_end,
    output logic                  mismatch
);

    logic c_is_end;

    // Word end coinciding with entry end is a full match; prefixes never match.
    always_comb begin
        c_is_sep  = (c == SEP);
        c_is_term = (c == TERM);
        v_is_term = (v == TERM);
        c_is_end  = c_is_sep || c_is_term;
        match     = c_is_end && v_is_term;
        advance   = !c_is_end && (c == v);
        vocab_end = !match && !advance && v_is_term && at_entry_start;
        mismatch  = !match && !advance && !vocab_end;
    end

endmodule

// File: rtl/token_encoder.sv
// Tokenizer front end: splits an input byte string into words, looks each up
// in a TERM-terminated vocab list and streams one token ID per word.
module token_encoder
    import tok_pkg::*;
#(
    parameter int unsigned              DATA_WIDTH  = 8,
    parameter int unsigned              IN_AW       = 8,
    parameter int unsigned              VOC_AW      = 10,
    parameter int unsigned              TOKEN_WIDTH = DEF_TOKEN_WIDTH,
    parameter logic [DATA_WIDTH-1:0]    SEP         = DEF_SEP,
    parameter logic [DATA_WIDTH-1:0]    TERM        = DEF_TERM,
    parameter logic [TOKEN_WIDTH-1:0]   UNK_ID      = '1,
    parameter int unsigned              MAX_TOKENS  = DEF_MAX_TOKENS
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [IN_AW-1:0]                  in_base,
    output logic                              busy,
    output logic                              done,
    output logic                              overflow,
    output logic [IN_AW-1:0]                  in_addr,
    input  logic [DATA_WIDTH-1:0]             in_rdata,
    output logic [VOC_AW-1:0]                 voc_addr,
    input  logic [DATA_WIDTH-1:0]             voc_rdata,
    output logic                              tok_valid,
    input  logic                              tok_ready,
    output logic [TOKEN_WIDTH-1:0]            tok_data,
    output logic                              tok_unk,
    output logic [$clog2(MAX_TOKENS+1)-1:0]   tok_count
);

    localparam int unsigned CW = $clog2(MAX_TOKENS + 1);

    state_t                 state_q, state_d;
    logic [IN_AW-1:0]       word_start_q;
    logic [VOC_AW-1:0]      entry_start_q;
    logic [TOKEN_WIDTH-1:0] id_q;

    logic c_is_sep, c_is_term, v_is_term;
    logic cmp_match, cmp_advance, cmp_vocab_end, cmp_mismatch;
    logic at_entry_start, vp_last, id_last, count_full;

    // Datapath strobes produced alongside the next state.
    logic act_start, wp_inc, word_begin, vp_inc, next_entry;
    logic emit_id, emit_unk, count_inc, set_ovf;

    assign at_entry_start = (voc_addr == entry_start_q);
    assign vp_last        = (voc_addr == '1);
    assign id_last        = (id_q == UNK_ID - 1'b1);
    assign count_full     = (tok_count == CW'(MAX_TOKENS));

    word_cmp #(
        .DATA_WIDTH (DATA_WIDTH),
        .SEP        (SEP),
        .TERM       (TERM)
    ) u_word_cmp (
        .c              (in_rdata),
        .v              (voc_rdata),
        .at_entry_start (at_entry_start),
        .c_is_sep       (c_is_sep),
        .c_is_term      (c_is_term),
        .v_is_term      (v_is_term),
        .match          (cmp_match),
        .advance        (cmp_advance),
        .vocab_end      (cmp_vocab_end),
        .mismatch       (cmp_mismatch)
    );

    // State register; reset aborts any run in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode; also raises the datapath strobes for this cycle.
    always_comb begin
        state_d    = state_q;
        act_start  = 1'b0;
        wp_inc     = 1'b0;
        word_begin = 1'b0;
        vp_inc     = 1'b0;
        next_entry = 1'b0;
        emit_id    = 1'b0;
        emit_unk   = 1'b0;
        count_inc  = 1'b0;
        set_ovf    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    act_start = 1'b1;
                    state_d   = ST_SKIP_ISSUE;
                end
            end
            ST_SKIP_ISSUE: state_d = ST_SKIP_CHECK;
            ST_SKIP_CHECK: begin
                if (c_is_term) begin
                    state_d = ST_DONE;
                end else if (c_is_sep) begin
                    wp_inc  = 1'b1;
                    state_d = ST_SKIP_ISSUE;
                end else begin
                    word_begin = 1'b1;
                    state_d    = ST_CMP_ISSUE;
                end
            end
            ST_CMP_ISSUE: state_d = ST_CMP_CHECK;
            ST_CMP_CHECK: begin
                if (cmp_match) begin
                    emit_id = 1'b1;
                    state_d = ST_EMIT;
                end else if (cmp_vocab_end) begin
                    emit_unk = 1'b1;
                    state_d  = ST_EMIT;
                end else if (cmp_mismatch) begin
                    state_d = ST_VSKIP_ISSUE;
                end else if (cmp_advance) begin
                    if (vp_last) begin
                        emit_unk = 1'b1;
                        state_d  = ST_EMIT;
                    end else begin
                        wp_inc  = 1'b1;
                        vp_inc  = 1'b1;
                        state_d = ST_CMP_ISSUE;
                    end
                end
            end
            ST_VSKIP_ISSUE: state_d = ST_VSKIP_CHECK;
            ST_VSKIP_CHECK: begin
                if (vp_last || (v_is_term && id_last)) begin
                    emit_unk = 1'b1;
                    state_d  = ST_EMIT;
                end else if (v_is_term) begin
                    next_entry = 1'b1;
                    state_d    = ST_CMP_ISSUE;
                end else begin
                    vp_inc  = 1'b1;
                    state_d = ST_VSKIP_ISSUE;
                end
            end
            ST_EMIT: begin
                if (tok_ready) begin
                    count_inc = 1'b1;
                    state_d   = ST_WEND_ISSUE;
                end
            end
            ST_WEND_ISSUE: state_d = ST_WEND_CHECK;
            // After a match the pointer is already on the end char; after UNK
            // it may be mid-word, so one scan covers both cases.
            ST_WEND_CHECK: begin
                if (c_is_term) begin
                    state_d = ST_DONE;
                end else if (c_is_sep) begin
                    if (count_full) begin
                        set_ovf = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SKIP_ISSUE;
                    end
                end else begin
                    wp_inc  = 1'b1;
                    state_d = ST_WEND_ISSUE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Status and stream-valid decode from the current state.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        tok_valid = 1'b0;
        case (state_q)
            ST_IDLE: ;
            ST_DONE: done = 1'b1;
            ST_EMIT: begin
                busy      = 1'b1;
                tok_valid = 1'b1;
            end
            default: busy = 1'b1;
        endcase
    end

    // Pointers, entry bookkeeping, token register and run counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_addr       <= '0;
            voc_addr      <= '0;
            word_start_q  <= '0;
            entry_start_q <= '0;
            id_q          <= '0;
            tok_data      <= '0;
            tok_unk       <= 1'b0;
            tok_count     <= '0;
            overflow      <= 1'b0;
        end else begin
            if (act_start) begin
                in_addr   <= in_base;
                tok_count <= '0;
                overflow  <= 1'b0;
            end else if (wp_inc) begin
                in_addr <= in_addr + 1'b1;
            end else if (next_entry) begin
                in_addr <= word_start_q;
            end
            if (word_begin) begin
                word_start_q  <= in_addr;
                voc_addr      <= '0;
                entry_start_q <= '0;
                id_q          <= '0;
            end else if (next_entry) begin
                voc_addr      <= voc_addr + 1'b1;
                entry_start_q <= voc_addr + 1'b1;
                id_q          <= id_q + 1'b1;
            end else if (vp_inc) begin
                voc_addr <= voc_addr + 1'b1;
            end
            if (emit_id) begin
                tok_data <= id_q;
                tok_unk  <= 1'b0;
            end else if (emit_unk) begin
                tok_data <= UNK_ID;
                tok_unk  <= 1'b1;
            end
            if (count_inc) tok_count <= tok_count + 1'b1;
            if (set_ovf)   overflow  <= 1'b1;
        end
    end

endmodule
